// File: rtl/conv_pe_ctrl.sv
// Sequencer for a 3x3 convolution PE: weight load, pixel streaming, window tagging.
// Optional stall counter output is enabled by defining CONV_PE_CTRL_STALL_CNT_EN.
module conv_pe_ctrl #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned CU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] w_data,
  output logic             wb_we,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             sr_shift,
  output logic             cu_en,
  output logic             out_valid,
  output logic [7:0]       out_row,
  output logic [7:0]       out_col,
`ifdef CONV_PE_CTRL_STALL_CNT_EN
  output logic             done,
  output logic [15:0]      stall_cnt
`else
  output logic             done
`endif
);

  if (IMG_W < 3 || IMG_W > 256) begin : g_bad_img_w
    $error("IMG_W out of range 3..256");
  end
  if (IMG_H < 3 || IMG_H > 256) begin : g_bad_img_h
    $error("IMG_H out of range 3..256");
  end
  if (CU_LAT > 7) begin : g_bad_cu_lat
    $error("CU_LAT out of range 0..7");
  end

  localparam logic [7:0] ColLast = 8'(IMG_W - 1);
  localparam logic [7:0] RowLast = 8'(IMG_H - 1);
  localparam logic [2:0] DrainLast = 3'(CU_LAT);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e     r_state;
  logic [3:0] r_widx;
  logic [7:0] r_row;
  logic [7:0] r_col;
  logic [2:0] r_dcnt;

  logic       r_pv [CU_LAT+1];
  logic [7:0] r_pr [CU_LAT+1];
  logic [7:0] r_pc [CU_LAT+1];

  logic w_w_acc;
  logic w_pix_acc;
  logic w_win;

  assign w_w_acc   = w_valid & w_ready;
  assign w_pix_acc = pix_valid & pix_ready;
  assign w_win     = w_pix_acc && (r_row >= 8'd2) && (r_col >= 8'd2);
  assign sr_shift  = w_pix_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_widx    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_dcnt    <= '0;
      busy      <= 1'b0;
      w_ready   <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      pix_ready <= 1'b0;
      cu_en     <= 1'b0;
      done      <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StLoadW;
            r_widx  <= '0;
            busy    <= 1'b1;
            w_ready <= 1'b1;
          end
        end
        StLoadW: begin
          if (w_w_acc) begin
            wb_we   <= 1'b1;
            wb_addr <= r_widx;
            wb_data <= w_data;
            r_widx  <= r_widx + 4'd1;
            if (r_widx == 4'd8) begin
              r_state   <= StStream;
              w_ready   <= 1'b0;
              pix_ready <= 1'b1;
              cu_en     <= 1'b1;
              r_row     <= '0;
              r_col     <= '0;
            end
          end
        end
        StStream: begin
          if (w_pix_acc) begin
            if (r_col == ColLast) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
            if (r_row == RowLast && r_col == ColLast) begin
              r_state   <= StDrain;
              pix_ready <= 1'b0;
              r_dcnt    <= '0;
            end
          end
        end
        StDrain: begin
          // Hold off done until the last window result has left the conv unit
          if (r_dcnt == DrainLast) begin
            r_state <= StDone;
            done    <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          busy    <= 1'b0;
          cu_en   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Coordinates only advance with a valid tag so the output holds the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= CU_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pr[i] <= '0;
        r_pc[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_win;
      if (w_win) begin
        r_pr[0] <= r_row - 8'd2;
        r_pc[0] <= r_col - 8'd2;
      end
      for (int unsigned i = 1; i <= CU_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pr[i] <= r_pr[i-1];
          r_pc[i] <= r_pc[i-1];
        end
      end
    end
  end

  assign out_valid = r_pv[CU_LAT];
  assign out_row   = r_pr[CU_LAT];
  assign out_col   = r_pc[CU_LAT];

`ifdef CONV_PE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (r_state == StIdle && start) begin
      stall_cnt <= '0;
    end else if (r_state == StStream && !pix_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Directed bench for conv_pe_ctrl on a 5x5 frame with CU_LAT=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conv_pe_ctrl;
  localparam int WIDTH  = 9;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int CU_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             w_valid = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             pix_valid = 1'b0;
  logic             busy, w_ready, wb_we, pix_ready, sr_shift, cu_en, out_valid, done;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [7:0]       out_row, out_col;
`ifdef CONV_PE_CTRL_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  conv_pe_ctrl #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CU_LAT(CU_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .sr_shift (sr_shift),
    .cu_en    (cu_en),
    .out_valid(out_valid),
    .out_row  (out_row),
    .out_col  (out_col),
`ifdef CONV_PE_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ov_cyc[$];
  logic [15:0] ov_rc[$];
  int done_cyc[$];
  int acc_cyc[$];

  // Expected window results for a 5x5 frame: {row, col} and the accept index producing each
  logic [15:0] exp_rc [9] = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101,
                              16'h0102, 16'h0200, 16'h0201, 16'h0202};
  int win_idx [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (out_valid === 1'b1) begin
      ov_cyc.push_back(cyc);
      ov_rc.push_back({out_row, out_col});
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    ov_cyc.delete();
    ov_rc.delete();
    done_cyc.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {24'd0, busy, w_ready, wb_we, pix_ready, sr_shift, cu_en, out_valid, done},
        32'd0);
    chk({tag, "_wb"}, {19'd0, wb_addr, wb_data}, 32'd0);
    chk({tag, "_coord"}, {16'd0, out_row, out_col}, 32'd0);
  endtask

  task automatic load_weights(input int stall_cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_w_ready", w_ready, 1);
    for (int i = 0; i < stall_cycles; i++) begin
      w_valid = 1'b0;
      w_data  = 9'h1AA;
      tick();
      chk("stall_w_ready", w_ready, 1);
      chk("stall_wb_we", wb_we, 0);
      chk("stall_pix_ready", pix_ready, 0);
    end
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1;
      w_data  = 9'(i + 1);
      tick();
      chk("wb_we", wb_we, 1);
      chk("wb_addr", wb_addr, i);
      chk("wb_data", wb_data, i + 1);
    end
    w_valid = 1'b0;
    chk("stream_pix_ready", pix_ready, 1);
    chk("stream_w_ready", w_ready, 0);
    chk("stream_cu_en", cu_en, 1);
  endtask

  task automatic stream(input int npix, input bit toggle, input int start_at);
    int k = 0;
    int j = 0;
    acc_cyc.delete();
    while (k < npix) begin
      pix_valid = toggle ? (j % 2 == 0) : 1'b1;
      start = (j == start_at);
      #1;
      chk("sr_shift", sr_shift, pix_valid);
      if (pix_valid) begin
        acc_cyc.push_back(cyc);
        k++;
      end
      tick();
      if (start) begin
        chk("start_ignored_w_ready", w_ready, 0);
        chk("start_ignored_pix_ready", pix_ready, 1);
      end
      start = 1'b0;
      j++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int lim = 0;
    while (done_cyc.size() == 0 && lim < 20) begin
      tick();
      lim++;
    end
    chk({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({tag, "_done_time"}, done_cyc[0], acc_cyc[24] + 4);
    tick();
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_cu_en_after"}, cu_en, 0);
    chk({tag, "_out_count"}, ov_cyc.size(), 9);
    for (int i = 0; i < 9 && i < ov_cyc.size(); i++) begin
      chk({tag, "_coord"}, ov_rc[i], exp_rc[i]);
      chk({tag, "_out_time"}, ov_cyc[i], acc_cyc[win_idx[i]] + 3);
    end
  endtask

  initial begin
    pix_valid = 1'b1;
    w_valid   = 1'b1;
    start     = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    start     = 1'b0;
    pix_valid = 1'b0;
    w_valid   = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Back-to-back frame with a 20-cycle weight stall
    clear_log();
    load_weights(20);
    stream(25, 1'b0, -1);
    finish_frame("b2b");

    // Alternating pixel valid, with a stray start mid-stream
    clear_log();
    load_weights(0);
    stream(25, 1'b1, 4);
    finish_frame("toggle");
`ifdef CONV_PE_CTRL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 24);
`endif

    // Reset after 10 pixels aborts the frame
    clear_log();
    load_weights(0);
    stream(10, 1'b0, -1);
    rst_n     = 1'b0;
    pix_valid = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (6) tick();
    chk("midrst_no_done", done_cyc.size(), 0);
    chk("midrst_no_out", ov_cyc.size(), 0);
    rst_n     = 1'b1;
    pix_valid = 1'b0;
    tick();

    clear_log();
    load_weights(0);
    stream(25, 1'b0, -1);
    finish_frame("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
